// File: rtl/game_flow_ctrl_pkg.sv
// rtl/game_flow_ctrl_pkg.sv - screen codes, menu sizes and stage helpers for the game sequencer
package game_flow_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_TITLE    = 4'd0,
        ST_STAFF    = 4'd1,
        ST_STAGE1   = 4'd2,
        ST_SUCCESS1 = 4'd3,
        ST_STAGE2   = 4'd4,
        ST_SUCCESS2 = 4'd5,
        ST_STAGE3   = 4'd6,
        ST_SUCCESS3 = 4'd7,
        ST_FAIL     = 4'd8
    } screen_t;

    localparam logic [1:0] MENU_TITLE  = 2'd3;
    localparam logic [1:0] MENU_PAIR   = 2'd2;
    localparam logic [1:0] MENU_SINGLE = 2'd1;

    function automatic logic [1:0] menu_size(input screen_t s);
        case (s)
            ST_TITLE:                                        return MENU_TITLE;
            ST_SUCCESS1, ST_SUCCESS2, ST_SUCCESS3, ST_FAIL:  return MENU_PAIR;
            default:                                         return MENU_SINGLE;
        endcase
    endfunction

    function automatic logic is_stage(input screen_t s);
        return (s == ST_STAGE1) || (s == ST_STAGE2) || (s == ST_STAGE3);
    endfunction

    function automatic screen_t stage_code(input logic [1:0] n);
        case (n)
            2'd2:    return ST_STAGE2;
            2'd3:    return ST_STAGE3;
            default: return ST_STAGE1;
        endcase
    endfunction

    function automatic logic [1:0] stage_num(input screen_t s);
        case (s)
            ST_STAGE2: return 2'd2;
            ST_STAGE3: return 2'd3;
            default:   return 2'd1;
        endcase
    endfunction

endpackage

// File: rtl/game_flow_ctrl_btn_edge.sv
// rtl/game_flow_ctrl_btn_edge.sv - rising-edge detector for one debounced button
module game_flow_ctrl_btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise
);

    logic prev_q;
    logic armed_q;

    // armed_q masks the first cycle after reset so a button already held does not fire
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            prev_q  <= level;
            armed_q <= 1'b1;
        end
    end

    assign rise = armed_q & level & ~prev_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// rtl/game_flow_ctrl.sv - screen sequencer: menu cursor, screen transitions and stage countdown
module game_flow_ctrl
    import game_flow_ctrl_pkg::*;
#(
    parameter int TICK_DIV     = 100_000_000,
    parameter int STAGE_TIME_S = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_enter,
    input  logic       stage_clear,
    input  logic       stage_fail,
    output logic [3:0] state,
    output logic [1:0] cursor,
    output logic [6:0] time_left,
    output logic       stage_start
);

    localparam int               PRE_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [6:0]       TIME_INIT = 7'(STAGE_TIME_S);

    logic             up_e, down_e, enter_e;
    screen_t          state_q, state_d;
    logic [1:0]       cursor_q, cursor_d;
    logic [1:0]       menu_m;
    logic [1:0]       last_stage_q;
    logic [PRE_W-1:0] prescaler_q;
    logic [6:0]       time_left_q;
    logic             stage_start_q;
    logic             in_stage, tick, lose_now, stage_entry;

    game_flow_ctrl_btn_edge u_edge_up    (.clk(clk), .rst(rst), .level(btn_up),    .rise(up_e));
    game_flow_ctrl_btn_edge u_edge_down  (.clk(clk), .rst(rst), .level(btn_down),  .rise(down_e));
    game_flow_ctrl_btn_edge u_edge_enter (.clk(clk), .rst(rst), .level(btn_enter), .rise(enter_e));

    assign in_stage    = is_stage(state_q);
    assign tick        = in_stage && (prescaler_q == PRE_LAST);
    assign lose_now    = stage_fail || (tick && (time_left_q == 7'd1));
    assign stage_entry = is_stage(state_d) && (state_d != state_q);

    always_comb begin
        state_d  = state_q;
        cursor_d = cursor_q;
        menu_m   = menu_size(state_q);
        case (state_q)
            ST_TITLE:    if (enter_e) state_d = stage_code(cursor_q + 2'd1);
            ST_STAGE1: begin
                if (stage_clear)   state_d = ST_SUCCESS1;
                else if (lose_now) state_d = ST_FAIL;
            end
            ST_STAGE2: begin
                if (stage_clear)   state_d = ST_SUCCESS2;
                else if (lose_now) state_d = ST_FAIL;
            end
            ST_STAGE3: begin
                if (stage_clear)   state_d = ST_SUCCESS3;
                else if (lose_now) state_d = ST_FAIL;
            end
            ST_SUCCESS1: if (enter_e) state_d = (cursor_q == 2'd0) ? ST_STAGE2 : ST_TITLE;
            ST_SUCCESS2: if (enter_e) state_d = (cursor_q == 2'd0) ? ST_STAGE3 : ST_TITLE;
            ST_SUCCESS3: if (enter_e) state_d = (cursor_q == 2'd0) ? ST_STAFF  : ST_TITLE;
            ST_FAIL:     if (enter_e) state_d = (cursor_q == 2'd0) ? stage_code(last_stage_q) : ST_TITLE;
            ST_STAFF:    if (enter_e) state_d = ST_TITLE;
            default:     state_d = ST_TITLE;
        endcase

        // enter takes priority over a simultaneous move; opposing moves cancel
        if (state_d != state_q) begin
            cursor_d = 2'd0;
        end else if (!enter_e) begin
            if (up_e && !down_e)
                cursor_d = (cursor_q == 2'd0) ? (menu_m - 2'd1) : (cursor_q - 2'd1);
            else if (down_e && !up_e)
                cursor_d = (cursor_q == (menu_m - 2'd1)) ? 2'd0 : (cursor_q + 2'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_TITLE;
            cursor_q     <= 2'd0;
            last_stage_q <= 2'd1;
        end else begin
            state_q  <= state_d;
            cursor_q <= cursor_d;
            if (stage_entry) last_stage_q <= stage_num(state_d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler_q   <= '0;
            time_left_q   <= 7'd0;
            stage_start_q <= 1'b0;
        end else begin
            stage_start_q <= stage_entry;
            if (stage_entry || !is_stage(state_d))
                prescaler_q <= '0;
            else if (tick)
                prescaler_q <= '0;
            else
                prescaler_q <= prescaler_q + 1'b1;

            if (stage_entry)
                time_left_q <= TIME_INIT;
            else if ((state_d == ST_TITLE) || (state_d == ST_STAFF))
                time_left_q <= 7'd0;
            else if (tick && (time_left_q != 7'd0))
                time_left_q <= time_left_q - 7'd1;
        end
    end

    assign state       = state_q;
    assign cursor      = cursor_q;
    assign time_left   = time_left_q;
    assign stage_start = stage_start_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb/tb_game_flow_ctrl.sv - randomized and directed bench for game_flow_ctrl against a screen-level model
module tb_game_flow_ctrl;

    localparam int TICK  = 4;
    localparam int STIME = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_enter = 1'b0;
    logic       stage_clear = 1'b0, stage_fail = 1'b0;
    logic [3:0] state;
    logic [1:0] cursor;
    logic [6:0] time_left;
    logic       stage_start;

    int checks = 0;
    int errors = 0;

    int m_state = 0, m_cursor = 0, m_time = 0, m_pulse = 0, m_last = 1, m_elapsed = 0;
    bit p_up = 0, p_dn = 0, p_en = 0, armed = 0;

    game_flow_ctrl #(.TICK_DIV(TICK), .STAGE_TIME_S(STIME)) dut (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_enter(btn_enter),
        .stage_clear(stage_clear), .stage_fail(stage_fail), .state(state), .cursor(cursor),
        .time_left(time_left), .stage_start(stage_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int menu(input int s);
        if (s == 0) return 3;
        if (s == 3 || s == 5 || s == 7 || s == 8) return 2;
        return 1;
    endfunction

    function automatic bit stage_scr(input int s);
        return s == 2 || s == 4 || s == 6;
    endfunction

    task automatic model(input bit r, u, d, e, c, f);
        bit ue, de, ee, tk;
        int ns, mm;
        if (r) begin
            m_state = 0; m_cursor = 0; m_time = 0; m_pulse = 0; m_last = 1; m_elapsed = 0;
            p_up = 0; p_dn = 0; p_en = 0; armed = 0;
            return;
        end
        ue = armed && u && !p_up;
        de = armed && d && !p_dn;
        ee = armed && e && !p_en;
        p_up = u; p_dn = d; p_en = e; armed = 1;
        tk = stage_scr(m_state) && (m_elapsed % TICK == TICK - 1);
        ns = m_state;
        case (m_state)
            0: if (ee) ns = 2 * m_cursor + 2;
            1: if (ee) ns = 0;
            2, 4, 6: if (c) ns = m_state + 1; else if (f || (tk && m_time == 1)) ns = 8;
            3, 5: if (ee) ns = (m_cursor == 0) ? m_state + 1 : 0;
            7: if (ee) ns = (m_cursor == 0) ? 1 : 0;
            8: if (ee) ns = (m_cursor == 0) ? 2 * m_last : 0;
            default: ns = 0;
        endcase
        m_pulse = 0;
        if (stage_scr(ns) && ns != m_state) begin
            m_time = STIME; m_elapsed = 0; m_pulse = 1; m_last = ns / 2;
        end else begin
            if (stage_scr(m_state)) begin
                if (tk && m_time > 0) m_time--;
                m_elapsed++;
            end
            if (ns == 0 || ns == 1) m_time = 0;
        end
        if (ns != m_state) m_cursor = 0;
        else if (!ee) begin
            mm = menu(m_state);
            if (ue && !de) m_cursor = (m_cursor + mm - 1) % mm;
            else if (de && !ue) m_cursor = (m_cursor + 1) % mm;
        end
        m_state = ns;
    endtask

    task automatic step(input bit r, u, d, e, c, f);
        rst = r; btn_up = u; btn_down = d; btn_enter = e; stage_clear = c; stage_fail = f;
        model(r, u, d, e, c, f);
        @(posedge clk);
        #1;
        check("state", state, m_state);
        check("cursor", cursor, m_cursor);
        check("time_left", time_left, m_time);
        check("stage_start", stage_start, m_pulse);
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic press(input bit u, d, e);
        step(0, u, d, e, 0, 0);
        idle();
    endtask

    initial begin
        @(negedge clk);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        check("rst_state", state, 0);
        check("rst_time", time_left, 0);
        idle();

        press(0, 1, 0);
        check("cur_1", cursor, 1);
        press(0, 1, 0);
        check("cur_2", cursor, 2);
        step(0, 0, 0, 1, 0, 0);
        check("enter_stage3", state, 6);
        check("enter_pulse", stage_start, 1);
        check("enter_time", time_left, 3);
        idle();
        check("pulse_one_cycle", stage_start, 0);
        for (int i = 0; i < 3; i++) idle();
        check("mid_time", time_left, 2);
        step(1, 0, 0, 0, 0, 0);
        check("midrst_state", state, 0);
        check("midrst_time", time_left, 0);
        check("midrst_pulse", stage_start, 0);
        step(1, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        check("held_at_release", state, 0);
        idle();

        step(0, 0, 0, 1, 0, 0);
        for (int i = 1; i <= 12; i++) begin
            idle();
            if (i == 4) check("t_tick1", time_left, 2);
            if (i == 8) check("t_tick2", time_left, 1);
            if (i == 11) check("pre_timeout", state, 2);
            if (i == 12) check("timeout", state, 8);
        end
        step(0, 0, 0, 1, 0, 0);
        check("retry_state", state, 2);
        check("retry_time", time_left, 3);
        check("retry_pulse", stage_start, 1);
        idle();
        step(0, 0, 0, 0, 1, 0);
        check("clear1", state, 3);
        idle();
        press(0, 0, 1);
        check("next2", state, 4);
        step(0, 0, 0, 0, 1, 1);
        check("clear_wins", state, 5);
        idle();
        press(0, 0, 1);
        check("next3", state, 6);
        step(0, 0, 0, 0, 1, 0);
        check("clear3", state, 7);
        idle();
        press(0, 1, 0);
        press(0, 0, 1);
        check("succ3_back", state, 0);
        press(0, 1, 0);
        press(0, 1, 0);
        press(0, 0, 1);
        step(0, 0, 0, 0, 1, 0);
        idle();
        press(0, 0, 1);
        check("staff", state, 1);
        press(0, 0, 1);
        check("staff_exit", state, 0);

        for (int i = 0; i < 100; i++) step(0, 0, 0, 1, 0, 0);
        check("held_once", state, 8);
        idle();
        press(0, 1, 0);
        press(0, 0, 1);
        check("fail_back", state, 0);
        press(1, 0, 0);
        check("up_wrap", cursor, 2);
        press(1, 1, 0);
        check("up_down_cancel", cursor, 2);
        press(0, 1, 1);
        check("enter_wins", state, 6);

        force dut.state_q = game_flow_ctrl_pkg::screen_t'(4'd12);
        #1;
        release dut.state_q;
        m_state = 12;
        idle();
        check("illegal_recover", state, 0);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 499) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
